// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, lane geometry
// and the byte-lane mask helper used on the load path.
package dmem_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = NUM_LANES * LANE_W;
    localparam int CNT_W     = 3;

    // Enable bit i covers bits [LANE_W*i +: LANE_W]; byte offset 0 therefore sits on bit NUM_LANES-1.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [NUM_LANES-1:0] en);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            m[i*LANE_W +: LANE_W] = {LANE_W{en[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Single-port word RAM built from one byte-wide bank per lane: synchronous
// per-lane write, combinational read of the addressed word.
module dmem_bank_ram
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [NUM_LANES-1:0] wen,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [2**ADDR_W];

            always_ff @(posedge clk) begin
                if (wen[gi]) begin
                    mem[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = mem[addr];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined CPU: stretches each access by WAIT_CYCLES
// via dstall, then performs a read-before-write byte-lane access on a local RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [3:0]  dre,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        dvalid,
    output logic        dstall
);

    localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        dout_q, dout_d;
    logic               dvalid_q, dvalid_d;

    logic               complete;
    logic               stall;
    logic [3:0]         ram_wen;
    logic [31:0]        ram_rdata;
    logic [ADDR_W-1:0]  word_addr;
    logic               unused_addr_bits;

    // Upper address bits are dropped on purpose, so the memory aliases across the 32-bit space.
    assign word_addr        = daddr[ADDR_W+1:2];
    assign unused_addr_bits = ^{daddr[31:ADDR_W+2], daddr[1:0]};

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dce && !NO_WAIT) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!dce) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset gates completion so an access caught mid-wait never reaches the RAM.
    always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        if (!cpu_rst && dce) begin
            case (state_q)
                ST_IDLE: begin
                    if (NO_WAIT) complete = 1'b1;
                    else         stall    = 1'b1;
                end
                ST_WAIT: begin
                    if (cnt_q != '0) stall    = 1'b1;
                    else             complete = 1'b1;
                end
                default: begin
                    stall    = 1'b0;
                    complete = 1'b0;
                end
            endcase
        end
        ram_wen  = complete ? we : 4'b0000;
        dvalid_d = complete && (dre != 4'b0000);
        dout_d   = dout_q;
        if (dvalid_d) begin
            dout_d = ram_rdata & lane_mask(dre);
        end
    end

    dmem_bank_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (cpu_clk_50M),
        .addr  (word_addr),
        .wen   (ram_wen),
        .wdata (din),
        .rdata (ram_rdata)
    );

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign dstall = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a zero-wait and a three-wait instance,
// directed corner cases followed by random traffic against a word-array model.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int NDUT   = 2;
    localparam int POOL   = 8;
    localparam int NRAND  = 60;
    localparam int WC_OF [NDUT] = '{0, 3};

    typedef struct {
        int          d;
        logic [31:0] v;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [NDUT];
    logic [31:0] daddr  [NDUT];
    logic        dce    [NDUT];
    logic [3:0]  we     [NDUT];
    logic [3:0]  dre    [NDUT];
    logic [31:0] din    [NDUT];
    logic [31:0] dout   [NDUT];
    logic        dvalid [NDUT];
    logic        dstall [NDUT];

    logic [31:0] model     [NDUT][1 << ADDR_W];
    logic [31:0] last_dout [NDUT];
    int          pool      [POOL];
    exp_t        sb[$];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            dmem_responder #(
                .ADDR_W      (ADDR_W),
                .WAIT_CYCLES (WC_OF[gi])
            ) u_dut (
                .cpu_clk_50M (clk),
                .cpu_rst     (rst[gi]),
                .daddr       (daddr[gi]),
                .dce         (dce[gi]),
                .we          (we[gi]),
                .dre         (dre[gi]),
                .din         (din[gi]),
                .dout        (dout[gi]),
                .dvalid      (dvalid[gi]),
                .dstall      (dstall[gi])
            );
        end
    endgenerate

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << ADDR_W));
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] en);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every dvalid must match the oldest expected read, due exactly one cycle after completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL dvalid_missing dut%0d: got no pulse, expected 0x%08h at cycle %0d", e.d, e.v, e.due);
        end
        for (int d = 0; d < NDUT; d++) begin
            if (rst[d] !== 1'b1) begin
                if (WC_OF[d] == 0) chk("dstall_wc0", {31'b0, dstall[d]}, 32'd0);
                if (dvalid[d] === 1'b1) begin
                    if (sb.size() == 0 || sb[0].d != d || sb[0].due != cyc) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dvalid_unexpected dut%0d: got pulse with 0x%08h, expected none", d, dout[d]);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("dout_dut%0d", d), dout[d], e.v);
                        last_dout[d] = e.v;
                    end
                end else begin
                    chk($sformatf("dout_hold_dut%0d", d), dout[d], last_dout[d]);
                end
            end
        end
    end

    task automatic access(input int d, input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                          input logic [31:0] data, input bit has_exp, input logic [31:0] exp_v);
        int          stalls;
        bit          done;
        int          wi;
        logic [31:0] pre;
        logic [31:0] m;
        exp_t        e;
        stalls = 0;
        done   = 1'b0;
        daddr[d] = a; we[d] = w; dre[d] = r; din[d] = data; dce[d] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (dstall[d] === 1'b0) begin
                wi  = widx(a);
                pre = model[d][wi];
                if (r != 4'b0000) begin
                    e.d   = d;
                    e.v   = has_exp ? exp_v : (pre & bmask(r));
                    e.due = cyc + 1;
                    sb.push_back(e);
                end
                m = bmask(w);
                model[d][wi] = (pre & ~m) | (data & m);
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 10) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stall_timeout dut%0d: got %0d stall cycles, expected %0d", d, stalls, WC_OF[d]);
                    done = 1'b1;
                end
            end
            step();
        end
        chk($sformatf("stall_cycles_dut%0d", d), 32'(stalls), 32'(WC_OF[d]));
        dce[d] = 1'b0; we[d] = 4'b0000; dre[d] = 4'b0000;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        last_dout[d] = '0;
        @(negedge clk);
        chk("rst_dstall_comb", {31'b0, dstall[d]}, 32'd0);
        step();
        @(negedge clk);
        chk("rst_dout", dout[d], 32'd0);
        chk("rst_dvalid", {31'b0, dvalid[d]}, 32'd0);
        chk("rst_dstall", {31'b0, dstall[d]}, 32'd0);
        step();
        rst[d] = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; daddr[d] = '0; dce[d] = 1'b0; we[d] = '0; dre[d] = '0; din[d] = '0;
            last_dout[d] = '0;
        end
        for (int d = 0; d < NDUT; d++) do_reset(d);

        // Zero-wait instance: word store/load, aliasing, read-before-write, no-op.
        access(0, 32'h0000_0010, 4'b1111, 4'b0000, 32'h7856_3412, 1'b0, '0);
        access(0, 32'h0000_0010, 4'b0000, 4'b1111, 32'h0,        1'b1, 32'h7856_3412);
        access(0, 32'h0000_1000, 4'b1111, 4'b0000, 32'hCAFE_F00D, 1'b0, '0);
        access(0, 32'h0000_0000, 4'b0000, 4'b1111, 32'h0,        1'b1, 32'hCAFE_F00D);
        access(0, 32'h0000_0040, 4'b1111, 4'b0000, 32'h0000_0005, 1'b0, '0);
        access(0, 32'h0000_0040, 4'b1111, 4'b1111, 32'h0000_0009, 1'b1, 32'h0000_0005);
        access(0, 32'h0000_0040, 4'b0000, 4'b1111, 32'h0,        1'b1, 32'h0000_0009);
        access(0, 32'h0000_0040, 4'b0000, 4'b0000, 32'hFFFF_FFFF, 1'b0, '0);
        access(0, 32'h0000_0040, 4'b0000, 4'b1111, 32'h0,        1'b1, 32'h0000_0009);

        // Three-wait instance: byte store/loads, then abort and reset mid-wait.
        access(1, 32'h0000_0020, 4'b1111, 4'b0000, 32'h1122_3344, 1'b0, '0);
        access(1, 32'h0000_0020, 4'b0010, 4'b0000, 32'hAAAA_AAAA, 1'b0, '0);
        access(1, 32'h0000_0020, 4'b0000, 4'b1111, 32'h0,        1'b1, 32'h1122_AA44);
        access(1, 32'h0000_0020, 4'b0000, 4'b0100, 32'h0,        1'b1, 32'h0022_0000);

        daddr[1] = 32'h20; we[1] = 4'b1111; dre[1] = 4'b0000; din[1] = 32'hDEAD_BEEF; dce[1] = 1'b1;
        @(negedge clk);
        chk("abort_stall_before", {31'b0, dstall[1]}, 32'd1);
        step();
        dce[1] = 1'b0;
        @(negedge clk);
        chk("abort_stall_after", {31'b0, dstall[1]}, 32'd0);
        step();
        we[1] = 4'b0000;
        access(1, 32'h0000_0020, 4'b0000, 4'b1111, 32'h0, 1'b1, 32'h1122_AA44);

        daddr[1] = 32'h20; we[1] = 4'b1111; din[1] = 32'h0BAD_F00D; dce[1] = 1'b1;
        @(negedge clk);
        chk("rstwait_stall_before", {31'b0, dstall[1]}, 32'd1);
        step();
        rst[1] = 1'b1;
        last_dout[1] = '0;
        @(negedge clk);
        chk("rstwait_stall_in_rst", {31'b0, dstall[1]}, 32'd0);
        step();
        @(negedge clk);
        chk("rstwait_dout", dout[1], 32'd0);
        chk("rstwait_dvalid", {31'b0, dvalid[1]}, 32'd0);
        step();
        rst[1] = 1'b0; dce[1] = 1'b0; we[1] = 4'b0000;
        access(1, 32'h0000_0020, 4'b0000, 4'b1111, 32'h0, 1'b1, 32'h1122_AA44);

        // Random traffic over a small pool of fully initialised words, with random alias bits.
        for (int k = 0; k < POOL; k++) pool[k] = int'($urandom_range(0, 127)) * POOL + k;
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < POOL; k++) begin
                a = (($urandom & 32'hFFFFF) << (ADDR_W + 2)) | (32'(pool[k]) << 2) | ($urandom & 32'h3);
                access(d, a, 4'b1111, 4'b0000, $urandom, 1'b0, '0);
            end
            for (int n = 0; n < NRAND; n++) begin
                a = (($urandom & 32'hFFFFF) << (ADDR_W + 2)) | (32'(pool[$urandom_range(0, POOL - 1)]) << 2)
                    | ($urandom & 32'h3);
                access(d, a, 4'($urandom), 4'($urandom), $urandom, 1'b0, '0);
                if ($urandom_range(0, 3) == 0) step();
            end
        end

        repeat (4) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal 0..7, meaning stall cycles inserted before each access completes.
REQ-003 SHALL have port cpu_clk_50M  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port cpu_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port daddr  input  32  meaning byte address from the memory stage.
REQ-006 SHALL have port dce  input  1  meaning access request, held by the initiator while dstall=1.
REQ-007 SHALL have port we  input  4  meaning byte-lane write enables: bit3 selects byte offset 0, bit0 selects offset 3.
REQ-008 SHALL have port dre  input  4  meaning byte-lane read enables, with the same lane mapping as we.
REQ-009 SHALL have port din  input  32  meaning store data, already lane-aligned by the initiator.
REQ-010 SHALL have port dout  output  32  meaning registered load data, with unselected lanes reading as zero.
REQ-011 SHALL have port dvalid  output  1  meaning one-cycle pulse marking dout valid for a completed read.
REQ-012 SHALL have port dstall  output  1  meaning the initiator must hold daddr/dce/we/dre/din and freeze its pipeline.

Function
REQ-013 SHALL index storage by word address daddr[ADDR_W+1:2]; higher address bits are ignored, so addresses alias and wrap.
REQ-014 SHALL use an FSM with states IDLE and WAIT, plus a 3-bit wait counter cnt.
REQ-015 In IDLE with dce=1 and WAIT_CYCLES=0, SHALL complete the access at this edge and keep dstall=0.
REQ-016 In IDLE with dce=1 and WAIT_CYCLES>0, SHALL assert dstall combinationally, enter WAIT and load cnt=WAIT_CYCLES-1.
REQ-017 In WAIT with dce=1 and cnt!=0, SHALL keep dstall=1 and decrement cnt.
REQ-018 In WAIT with dce=1 and cnt=0, SHALL drive dstall=0, complete the access at this edge and return to IDLE.
REQ-019 In WAIT with dce=0 (aborted by the initiator), SHALL return to IDLE with no write, no dvalid and dstall=0.
REQ-020 On completion, SHALL write din lane i into memory lane i for every we[i]=1.
REQ-021 On completion with dre!=0, SHALL register dout as (stored word masked by dre) and pulse dvalid the next cycle.
REQ-022 When we and dre are both nonzero, SHALL return the pre-write contents (read-before-write).
REQ-023 On a read completing the cycle after a write to the same word, SHALL return the newly written data.
REQ-024 SHALL accept we/dre patterns verbatim with no alignment checking; dce=1 with we=dre=0 completes as a no-op.
REQ-025 SHALL hold dout at its last value when dvalid=0.
REQ-026 SHALL accept back-to-back requests: IDLE may accept a new request in the cycle after a completion.

Reset
REQ-027 While cpu_rst=1, SHALL force state=IDLE, cnt=0, dout=0, dvalid=0 and dstall=0.
REQ-028 SHALL leave memory contents unchanged by reset, and a reset during WAIT SHALL abort the access with no write.

Structure
REQ-029 SHALL place FSM state encodings and the lane-index constants in the shared defines file.
REQ-030 SHALL use one sub-module, dmem_bank_ram: a single-port byte-write-enable RAM with synchronous write and combinational read.

Verification
REQ-031 WAIT_CYCLES=0: SW 0x00000010 with we=1111 and din=0x78563412, then LW with dre=1111 -> dout=0x78563412, dvalid one cycle later, dstall never 1.
REQ-032 WAIT_CYCLES=3: LW held -> dstall=1 for exactly 3 cycles, completes on the 4th edge, dvalid pulses once.
REQ-033 SB with we=0010 and din=0xAAAAAAAA over word 0x11223344, then LW -> 0x1122AA44; LB with dre=0100 -> 0x00220000.
REQ-034 Aliasing: write address 0x00001000 with ADDR_W=10, then read address 0x00000000 -> same data.
REQ-035 Abort and reset: dce dropped mid-WAIT -> no write; cpu_rst pulsed mid-WAIT -> outputs zero and memory unchanged.
REQ-036 we=1111 and dre=1111 on a word holding 0x5 with din=0x9 -> dout=0x5, then a subsequent read returns 0x9.
